nes_controller_emulator: RTL and testbench

//  Device-side NES controller: the responder to nes_controller_interface.

---
 rtl/nes_controller_emulator_if.sv | 35 +++
 rtl/nes_controller_emulator.sv | 117 +++++++++++
 tb/tb_nes_controller_emulator.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/nes_controller_emulator_if.sv
// Pad-side pins and status of the NES controller emulator.
// The master side is the host or harness; the slave side is the emulated pad.
interface nes_controller_emulator_if #(
  parameter int unsigned NUM_BITS = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_BITS + 1);

  logic [NUM_BITS-1:0] buttons_i;
  logic                controller_latch_i;
  logic                controller_clk_i;
  logic                controller_serial_no;
  logic                busy_o;
  logic                frame_done_o;
  logic [IDX_W-1:0]    bit_index_o;

  modport master (
    output buttons_i,
    output controller_latch_i,
    output controller_clk_i,
    input  controller_serial_no,
    input  busy_o,
    input  frame_done_o,
    input  bit_index_o
  );

  modport slave (
    input  buttons_i,
    input  controller_latch_i,
    input  controller_clk_i,
    output controller_serial_no,
    output busy_o,
    output frame_done_o,
    output bit_index_o
  );
endinterface

// File: rtl/nes_controller_emulator.sv
// Device-side NES pad: parallel-loads buttons on latch, shifts them out LSB first
// on each rising controller clock over an active-low serial line.
module nes_controller_emulator #(
  parameter int unsigned NUM_BITS    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        FILL_BIT    = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_ni,
  nes_controller_emulator_if.slave      bus
);

  localparam int unsigned IDX_W = $clog2(NUM_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic [SYNC_STAGES-1:0] r_cclk_sync;
  logic                   r_cclk_prev;
  logic [NUM_BITS-1:0]    r_shreg;
  logic [NUM_BITS-1:0]    w_shreg_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic                   r_serial_n;
  logic                   w_latch_s;
  logic                   w_cclk_s;
  logic                   w_cclk_rise;

  assign w_latch_s   = r_latch_sync[SYNC_STAGES-1];
  assign w_cclk_s    = r_cclk_sync[SYNC_STAGES-1];
  assign w_cclk_rise = w_cclk_s & ~r_cclk_prev;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_latch_sync <= '0;
      r_cclk_sync  <= '0;
      r_cclk_prev  <= 1'b0;
    end else begin
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], bus.controller_latch_i};
      r_cclk_sync  <= {r_cclk_sync[SYNC_STAGES-2:0], bus.controller_clk_i};
      r_cclk_prev  <= w_cclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_serial_n <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_idx      <= w_idx_nxt;
      r_done     <= w_done_nxt;
      // Driven from the next shift value so the pin tracks shreg[0] without lag.
      r_serial_n <= ~w_shreg_nxt[0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    // Latch level is checked ahead of the state case: it beats a same-cycle
    // clock rise everywhere and loads on the very cycle LOAD is entered.
    if (w_latch_s) begin
      w_state_nxt = S_LOAD;
      w_shreg_nxt = bus.buttons_i;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
        end
        S_LOAD: begin
          w_state_nxt = S_SHIFT;
        end
        S_SHIFT: begin
          if (w_cclk_rise) begin
            w_shreg_nxt = {FILL_BIT, r_shreg[NUM_BITS-1:1]};
            w_idx_nxt   = r_idx + IDX_W'(1);
            if (r_idx == LAST_IDX) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (w_cclk_rise) begin
            w_shreg_nxt = {FILL_BIT, r_shreg[NUM_BITS-1:1]};
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.controller_serial_no = r_serial_n;
  assign bus.busy_o               = (r_state == S_SHIFT);
  assign bus.frame_done_o         = r_done;
  assign bus.bit_index_o          = r_idx;

endmodule

// File: tb/tb_nes_controller_emulator.sv
// Self-checking bench: a behavioural NES host drives latch/clock pins and
// decodes the serial line against the button word it loaded.
module tb_nes_controller_emulator;
  localparam int unsigned NB = 8;
  localparam int unsigned SS = 2;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  nes_controller_emulator_if #(.NUM_BITS(NB)) bus ();

  nes_controller_emulator #(
    .NUM_BITS   (NB),
    .SYNC_STAGES(SS),
    .FILL_BIT   (1'b1)
  ) dut (
    .clk   (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.frame_done_o === 1'b1) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected active-low line after k shifts of a frame loaded with b.
  function automatic logic exp_serial(input logic [NB-1:0] b, input int k);
    logic v;
    if (k < int'(NB)) v = b[k];
    else              v = 1'b1;
    return ~v;
  endfunction

  task automatic latch_pulse(input int hi);
    bus.controller_latch_i = 1'b1;
    cyc(hi);
    bus.controller_latch_i = 1'b0;
    cyc(SS + 3);
  endtask

  task automatic cclk_pulse(input int hi, input int lo);
    bus.controller_clk_i = 1'b1;
    cyc(hi);
    bus.controller_clk_i = 1'b0;
    cyc(lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NB-1:0] b;
    logic [NB-1:0] rd;
    int d0;

    bus.buttons_i          = '0;
    bus.controller_latch_i = 1'b0;
    bus.controller_clk_i   = 1'b0;

    // Reset with random pin activity
    rst_ni = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.buttons_i          = NB'($urandom);
      bus.controller_latch_i = 1'($urandom);
      bus.controller_clk_i   = 1'($urandom);
      cyc(1);
    end
    check_eq("rst_serial", 32'(bus.controller_serial_no), 32'd1);
    check_eq("rst_busy",   32'(bus.busy_o),               32'd0);
    check_eq("rst_index",  32'(bus.bit_index_o),          32'd0);
    check_eq("rst_done",   32'(bus.frame_done_o),         32'd0);
    bus.controller_latch_i = 1'b0;
    bus.controller_clk_i   = 1'b0;
    cyc(SS + 1);
    rst_ni = 1'b1;
    cyc(2);

    // Basic frame
    b = 8'b1010_0101;
    bus.buttons_i = b;
    d0 = done_cnt;
    latch_pulse(4);
    for (int k = 0; k < int'(NB); k++) begin
      check_eq($sformatf("basic_serial%0d", k), 32'(bus.controller_serial_no), 32'(exp_serial(b, k)));
      check_eq($sformatf("basic_index%0d", k),  32'(bus.bit_index_o),          32'(k));
      check_eq($sformatf("basic_busy%0d", k),   32'(bus.busy_o),               32'd1);
      cclk_pulse(6, 6);
    end
    check_eq("basic_done_cnt", 32'(done_cnt - d0),        32'd1);
    check_eq("basic_index_end", 32'(bus.bit_index_o),     32'(NB));
    check_eq("basic_busy_end", 32'(bus.busy_o),           32'd0);
    check_eq("basic_fill",     32'(bus.controller_serial_no), 32'd0);

    // Overclock past the frame
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) begin
      cclk_pulse(6, 6);
      check_eq($sformatf("over_serial%0d", k), 32'(bus.controller_serial_no), 32'd0);
      check_eq($sformatf("over_index%0d", k),  32'(bus.bit_index_o),          32'(NB));
    end
    check_eq("over_done_cnt", 32'(done_cnt - d0), 32'd0);

    // Latch and controller clock rise together
    b = NB'($urandom) & ~NB'(1);
    d0 = done_cnt;
    bus.buttons_i          = b;
    bus.controller_latch_i = 1'b1;
    bus.controller_clk_i   = 1'b1;
    cyc(4);
    bus.controller_latch_i = 1'b0;
    cyc(2);
    bus.controller_clk_i   = 1'b0;
    cyc(SS + 3);
    check_eq("prio_serial",   32'(bus.controller_serial_no), 32'(exp_serial(b, 0)));
    check_eq("prio_index",    32'(bus.bit_index_o),          32'd0);
    check_eq("prio_busy",     32'(bus.busy_o),               32'd1);
    check_eq("prio_done_cnt", 32'(done_cnt - d0),            32'd0);

    // Early re-latch after 3 shifts
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("early_serial%0d", k), 32'(bus.controller_serial_no), 32'(exp_serial(b, k)));
      cclk_pulse(6, 6);
    end
    check_eq("early_index3", 32'(bus.bit_index_o), 32'd3);
    bus.buttons_i = '1;
    latch_pulse(4);
    check_eq("relatch_serial",   32'(bus.controller_serial_no), 32'd0);
    check_eq("relatch_index",    32'(bus.bit_index_o),          32'd0);
    check_eq("relatch_done_cnt", 32'(done_cnt - d0),            32'd0);
    for (int k = 0; k < int'(NB); k++) begin
      check_eq($sformatf("ff_serial%0d", k), 32'(bus.controller_serial_no), 32'd0);
      cclk_pulse(6, 6);
    end
    check_eq("ff_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("ff_index",    32'(bus.bit_index_o), 32'(NB));

    // Mid-frame reset after 5 shifts
    b = NB'($urandom);
    bus.buttons_i = b;
    latch_pulse(4);
    for (int k = 0; k < 5; k++) cclk_pulse(6, 6);
    check_eq("mid_index5", 32'(bus.bit_index_o), 32'd5);
    d0 = done_cnt;
    rst_ni = 1'b0;
    cyc(2);
    check_eq("mid_rst_serial", 32'(bus.controller_serial_no), 32'd1);
    check_eq("mid_rst_busy",   32'(bus.busy_o),               32'd0);
    check_eq("mid_rst_index",  32'(bus.bit_index_o),          32'd0);
    check_eq("mid_rst_done",   32'(bus.frame_done_o),         32'd0);
    rst_ni = 1'b1;
    cyc(3);
    check_eq("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);

    // Jittered host frames; buttons change once the load window has closed
    for (int f = 0; f < 8; f++) begin
      b = NB'($urandom);
      bus.buttons_i = b;
      d0 = done_cnt;
      bus.controller_latch_i = 1'b1;
      cyc(int'($urandom_range(1, 7)));
      bus.controller_latch_i = 1'b0;
      cyc(SS + 2);
      bus.buttons_i = NB'($urandom);
      rd = '0;
      for (int k = 0; k < int'(NB); k++) begin
        cyc(int'($urandom_range(3, 9)));
        rd[k] = ~bus.controller_serial_no;
        bus.controller_clk_i = 1'b1;
        cyc(int'($urandom_range(3, 9)));
        bus.controller_clk_i = 1'b0;
      end
      cyc(SS + 3);
      check_eq($sformatf("jit_decode%0d", f),   32'(rd),              32'(b));
      check_eq($sformatf("jit_done_cnt%0d", f), 32'(done_cnt - d0),   32'd1);
      check_eq($sformatf("jit_index%0d", f),    32'(bus.bit_index_o), 32'(NB));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
